// File: rtl/imu_pkg.sv
// Shared definitions for the IMU filter: axis lane positions in the packed
// 48-bit words, channel indices of the time-multiplexed path, FSM states
// and the 17-to-16-bit saturating helper.
package imu_pkg;

  localparam int unsigned W   = 16;
  localparam int unsigned NCH = 6;

  localparam int unsigned AX_X_MSB = 47;
  localparam int unsigned AX_X_LSB = 32;
  localparam int unsigned AX_Y_MSB = 31;
  localparam int unsigned AX_Y_LSB = 16;
  localparam int unsigned AX_Z_MSB = 15;
  localparam int unsigned AX_Z_LSB = 0;

  localparam logic [2:0] CH_ACC_X = 3'd0;
  localparam logic [2:0] CH_ACC_Y = 3'd1;
  localparam logic [2:0] CH_ACC_Z = 3'd2;
  localparam logic [2:0] CH_GYR_X = 3'd3;
  localparam logic [2:0] CH_GYR_Y = 3'd4;
  localparam logic [2:0] CH_GYR_Z = 3'd5;

  typedef enum logic [1:0] {
    ST_CALIB = 2'd0,
    ST_IDLE  = 2'd1,
    ST_PROC  = 2'd2
  } state_e;

  // One three-axis sample word, x in the top lane.
  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
  } axis3_t;

  // Clamp a 17-bit signed value into the signed 16-bit range.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v[16] != v[15]) begin
      sat16 = v[16] ? 16'sh8000 : 16'sh7fff;
    end else begin
      sat16 = v[15:0];
    end
  endfunction

endpackage

// File: rtl/imu_filter_iir_lane.sv
// iir_lane: combinational single-channel datapath.
//   raw_i     raw 16-bit sample
//   bias_i    offset removed from raw (0 for accel channels)
//   y_old_i   current filter state
//   y_new_c   next filter state: y + ((sat16(raw - bias) - y) >>> ALPHA_SHIFT)
module iir_lane
  import imu_pkg::*;
#(
  parameter int unsigned ALPHA_SHIFT = 2
) (
  input  logic signed [15:0] raw_i,
  input  logic signed [15:0] bias_i,
  input  logic signed [15:0] y_old_i,
  output logic signed [15:0] y_new_c
);

  logic signed [16:0] diff;
  logic signed [15:0] corr;
  logic signed [16:0] delta;
  logic signed [16:0] step;

  always_comb begin
    diff  = $signed({raw_i[15], raw_i}) - $signed({bias_i[15], bias_i});
    corr  = sat16(diff);
    // corr - y always fits 17 bits; the shift floors toward -inf.
    delta = $signed({corr[15], corr}) - $signed({y_old_i[15], y_old_i});
    step  = delta >>> ALPHA_SHIFT;
    // The sum lies between y_old and corr, so truncation is lossless.
    y_new_c = 16'($signed({y_old_i[15], y_old_i}) + step);
  end

endmodule

// File: rtl/imu_filter.sv
// imu_filter: start-up gyro bias calibration followed by bias removal and a
// shift-based first-order IIR on six axes through one shared lane.
//   clk, rst      clock, synchronous active-high reset
//   in_valid      new acc/gyr sample strobe
//   acc, gyr      packed signed {x,y,z} 16-bit words
//   recal         restart calibration
//   acc_filt      filtered accel
//   gyr_filt      bias-corrected filtered gyro
//   out_valid     filtered words updated this cycle
//   calibrated    bias is valid
//   overrun       sticky: a sample was dropped while busy
module imu_filter
  import imu_pkg::*;
#(
  parameter int unsigned CAL_BITS    = 8,
  parameter int unsigned ALPHA_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [47:0] acc,
  input  logic [47:0] gyr,
  input  logic        recal,
  output logic [47:0] acc_filt,
  output logic [47:0] gyr_filt,
  output logic        out_valid,
  output logic        calibrated,
  output logic        overrun
);

  localparam int unsigned SW = W + CAL_BITS;

  state_e                     state_q, state_d;
  logic [CAL_BITS-1:0]        cnt_q, cnt_d;
  logic [2:0]                 ch_q, ch_d;
  logic signed [SW-1:0]       sum_q [3];
  logic signed [SW-1:0]       sum_d [3];
  logic signed [SW-1:0]       sum_nx [3];
  logic signed [15:0]         bias_q [3];
  logic signed [15:0]         bias_d [3];
  logic signed [15:0]         raw_q [NCH];
  logic signed [15:0]         raw_d [NCH];
  logic signed [15:0]         y_q [NCH];
  logic signed [15:0]         y_d [NCH];
  logic signed [15:0]         in_ch [NCH];
  logic [47:0]                acc_filt_q, acc_filt_d;
  logic [47:0]                gyr_filt_q, gyr_filt_d;
  logic                       out_valid_q, out_valid_d;
  logic                       calibrated_q, calibrated_d;
  logic                       overrun_q, overrun_d;

  logic signed [15:0]         lane_raw, lane_bias, lane_y, lane_y_new;
  axis3_t                     acc_s, gyr_s;

  // Unpack the input words into channel order.
  always_comb begin
    acc_s = acc;
    gyr_s = gyr;
    in_ch[CH_ACC_X] = acc_s.x;
    in_ch[CH_ACC_Y] = acc_s.y;
    in_ch[CH_ACC_Z] = acc_s.z;
    in_ch[CH_GYR_X] = gyr_s.x;
    in_ch[CH_GYR_Y] = gyr_s.y;
    in_ch[CH_GYR_Z] = gyr_s.z;
  end

  // Calibration accumulators including the sample currently presented.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sum_nx[i] = sum_q[i] + SW'(in_ch[3 + i]);
    end
  end

  // Shared lane operand select; accel channels see zero bias.
  always_comb begin
    lane_raw  = raw_q[ch_q];
    lane_y    = y_q[ch_q];
    lane_bias = '0;
    case (ch_q)
      CH_GYR_X: lane_bias = bias_q[0];
      CH_GYR_Y: lane_bias = bias_q[1];
      CH_GYR_Z: lane_bias = bias_q[2];
      default:  lane_bias = '0;
    endcase
  end

  iir_lane #(
    .ALPHA_SHIFT(ALPHA_SHIFT)
  ) u_lane (
    .raw_i   (lane_raw),
    .bias_i  (lane_bias),
    .y_old_i (lane_y),
    .y_new_c (lane_y_new)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ch_d         = ch_q;
    sum_d        = sum_q;
    bias_d       = bias_q;
    raw_d        = raw_q;
    y_d          = y_q;
    acc_filt_d   = acc_filt_q;
    gyr_filt_d   = gyr_filt_q;
    out_valid_d  = 1'b0;
    calibrated_d = calibrated_q;
    overrun_d    = overrun_q;

    if (recal) begin
      // Restart calibration; filtered outputs and overrun are kept.
      state_d      = ST_CALIB;
      cnt_d        = '0;
      ch_d         = CH_ACC_X;
      sum_d        = '{default: '0};
      bias_d       = '{default: '0};
      y_d          = '{default: '0};
      calibrated_d = 1'b0;
    end else begin
      case (state_q)
        ST_CALIB: begin
          if (in_valid) begin
            cnt_d = cnt_q + CAL_BITS'(1);
            if (cnt_q == '1) begin
              for (int i = 0; i < 3; i++) begin
                bias_d[i] = 16'(sum_nx[i] >>> CAL_BITS);
              end
              sum_d        = '{default: '0};
              y_d          = '{default: '0};
              calibrated_d = 1'b1;
              state_d      = ST_IDLE;
            end else begin
              sum_d = sum_nx;
            end
          end
        end
        ST_IDLE: begin
          if (in_valid) begin
            raw_d   = in_ch;
            ch_d    = CH_ACC_X;
            state_d = ST_PROC;
          end
        end
        ST_PROC: begin
          if (in_valid) begin
            overrun_d = 1'b1;
          end
          y_d[ch_q] = lane_y_new;
          if (ch_q == CH_GYR_Z) begin
            acc_filt_d[AX_X_MSB:AX_X_LSB] = y_d[CH_ACC_X];
            acc_filt_d[AX_Y_MSB:AX_Y_LSB] = y_d[CH_ACC_Y];
            acc_filt_d[AX_Z_MSB:AX_Z_LSB] = y_d[CH_ACC_Z];
            gyr_filt_d[AX_X_MSB:AX_X_LSB] = y_d[CH_GYR_X];
            gyr_filt_d[AX_Y_MSB:AX_Y_LSB] = y_d[CH_GYR_Y];
            gyr_filt_d[AX_Z_MSB:AX_Z_LSB] = y_d[CH_GYR_Z];
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            ch_d = ch_q + 3'd1;
          end
        end
        default: state_d = ST_CALIB;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CALIB;
      cnt_q        <= '0;
      ch_q         <= '0;
      sum_q        <= '{default: '0};
      bias_q       <= '{default: '0};
      raw_q        <= '{default: '0};
      y_q          <= '{default: '0};
      acc_filt_q   <= '0;
      gyr_filt_q   <= '0;
      out_valid_q  <= 1'b0;
      calibrated_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      sum_q        <= sum_d;
      bias_q       <= bias_d;
      raw_q        <= raw_d;
      y_q          <= y_d;
      acc_filt_q   <= acc_filt_d;
      gyr_filt_q   <= gyr_filt_d;
      out_valid_q  <= out_valid_d;
      calibrated_q <= calibrated_d;
      overrun_q    <= overrun_d;
    end
  end

  assign acc_filt   = acc_filt_q;
  assign gyr_filt   = gyr_filt_q;
  assign out_valid  = out_valid_q;
  assign calibrated = calibrated_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_imu_filter.sv
// Scoreboard bench for imu_filter: two instances (ALPHA_SHIFT 0 and 2, CAL_BITS 4)
// share one stimulus stream; expected words and arrival cycles are queued per
// instance and popped by a monitor on every out_valid.
module tb_imu_filter;

  typedef struct {
    logic [47:0] a;
    logic [47:0] g;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, recal;
  logic [47:0] acc, gyr;
  logic [47:0] acc_filt0, gyr_filt0, acc_filt2, gyr_filt2;
  logic        out_valid0, calibrated0, overrun0;
  logic        out_valid2, calibrated2, overrun2;

  int   cyc   = 0;
  int   nvec  = 0;
  int   nerr  = 0;
  exp_t q0[$];
  exp_t q2[$];
  exp_t e0, e2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imu_filter #(.CAL_BITS(4), .ALPHA_SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .acc(acc), .gyr(gyr), .recal(recal),
    .acc_filt(acc_filt0), .gyr_filt(gyr_filt0), .out_valid(out_valid0),
    .calibrated(calibrated0), .overrun(overrun0)
  );

  imu_filter #(.CAL_BITS(4), .ALPHA_SHIFT(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .acc(acc), .gyr(gyr), .recal(recal),
    .acc_filt(acc_filt2), .gyr_filt(gyr_filt2), .out_valid(out_valid2),
    .calibrated(calibrated2), .overrun(overrun2)
  );

  function automatic logic [47:0] pk(input int x, input int y, input int z);
    return {16'(x), 16'(y), 16'(z)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One-cycle in_valid pulse; returns the cycle in which it was presented.
  task automatic send(input logic [47:0] a, input logic [47:0] g, output int t);
    t        = cyc;
    acc      = a;
    gyr      = g;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [47:0] a0, input logic [47:0] g0,
                      input logic [47:0] a2, input logic [47:0] g2, input int t);
    exp_t e;
    e.cyc = t + 7;
    e.a = a0; e.g = g0; q0.push_back(e);
    e.a = a2; e.g = g2; q2.push_back(e);
  endtask

  // Monitors: every out_valid must match the head of its queue at the right cycle.
  always @(negedge clk) begin
    if (out_valid0) begin
      nvec++;
      if (q0.size() == 0) begin
        nerr++;
        $display("FAIL dut0 unexpected out_valid at cycle %0d", cyc);
      end else begin
        e0 = q0.pop_front();
        if ({acc_filt0, gyr_filt0} !== {e0.a, e0.g} || cyc != e0.cyc) begin
          nerr++;
          $display("FAIL dut0 output: got %h %h @%0d expected %h %h @%0d",
                   acc_filt0, gyr_filt0, cyc, e0.a, e0.g, e0.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid2) begin
      nvec++;
      if (q2.size() == 0) begin
        nerr++;
        $display("FAIL dut2 unexpected out_valid at cycle %0d", cyc);
      end else begin
        e2 = q2.pop_front();
        if ({acc_filt2, gyr_filt2} !== {e2.a, e2.g} || cyc != e2.cyc) begin
          nerr++;
          $display("FAIL dut2 output: got %h %h @%0d expected %h %h @%0d",
                   acc_filt2, gyr_filt2, cyc, e2.a, e2.g, e2.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1; in_valid = 1'b0; recal = 1'b0; acc = '0; gyr = '0;
    tick(); tick();
    check("reset dut0", {acc_filt0, gyr_filt0, out_valid0, calibrated0, overrun0}, '0);
    check("reset dut2", {acc_filt2, gyr_filt2, out_valid2, calibrated2, overrun2}, '0);
    rst = 1'b0;
    tick();

    // Calibration: 16 samples of gyr = {100,-50,7}.
    for (int i = 0; i < 15; i++) send(pk(0, 0, 0), pk(100, -50, 7), t);
    check("cal before 16th", {calibrated0, calibrated2}, 2'b00);
    send(pk(0, 0, 0), pk(100, -50, 7), t);
    check("cal after 16th", {calibrated0, calibrated2}, 2'b11);
    tick();

    // Three identical samples; the second and third arrive in the out_valid cycle.
    send(pk(1000, -1000, 0), pk(100, -50, 7), t);
    push(pk(1000, -1000, 0), pk(0, 0, 0), pk(250, -250, 0), pk(0, 0, 0), t);
    repeat (6) tick();
    send(pk(1000, -1000, 0), pk(100, -50, 7), t);
    push(pk(1000, -1000, 0), pk(0, 0, 0), pk(437, -438, 0), pk(0, 0, 0), t);
    check("no overrun at T+7", {overrun0, overrun2}, 2'b00);
    repeat (6) tick();
    send(pk(1000, -1000, 0), pk(100, -50, 7), t);
    push(pk(1000, -1000, 0), pk(0, 0, 0), pk(577, -579, 0), pk(0, 0, 0), t);
    tick(); tick();
    // Sample at T+3 must be dropped and flagged.
    send(pk(5, 5, 5), pk(5, 5, 5), t);
    check("overrun set", {overrun0, overrun2}, 2'b11);
    repeat (12) tick();

    // recal at T+4 of a sample in flight: no output, outputs hold.
    send(pk(2000, 2000, 2000), pk(0, 0, 0), t);
    tick(); tick(); tick();
    recal = 1'b1;
    tick();
    recal = 1'b0;
    check("recal calibrated", {calibrated0, calibrated2}, 2'b00);
    check("recal hold dut0", {acc_filt0, gyr_filt0}, {pk(1000, -1000, 0), pk(0, 0, 0)});
    check("recal hold dut2", {acc_filt2, gyr_filt2}, {pk(577, -579, 0), pk(0, 0, 0)});
    check("recal keeps overrun", {overrun0, overrun2}, 2'b11);
    repeat (10) tick();

    // Garbage partial calibration, then recal together with in_valid.
    for (int i = 0; i < 5; i++) send(pk(0, 0, 0), pk(1000, 1000, 1000), t);
    recal = 1'b1;
    send(pk(0, 0, 0), pk(1000, 1000, 1000), t);
    recal = 1'b0;
    // Bias {-100, 100, -2}: z sums to -17, floored to -2.
    for (int i = 0; i < 15; i++) send(pk(0, 0, 0), pk(-100, 100, -1), t);
    check("recal before 16th", {calibrated0, calibrated2}, 2'b00);
    send(pk(0, 0, 0), pk(-100, 100, -2), t);
    check("recal after 16th", {calibrated0, calibrated2}, 2'b11);
    tick();

    // Saturation on both rails, bias floor, and y=0 -> -1 step.
    send(pk(-1, 0, 0), pk(32767, -32768, -3), t);
    push(pk(-1, 0, 0), pk(32767, -32768, -1), pk(-1, 0, 0), pk(8191, -8192, -1), t);
    repeat (10) tick();

    // rst in the middle of calibration.
    recal = 1'b1;
    tick();
    recal = 1'b0;
    for (int i = 0; i < 3; i++) send(pk(0, 0, 0), pk(9, 9, 9), t);
    rst = 1'b1;
    tick();
    check("mid rst dut0", {acc_filt0, gyr_filt0, out_valid0, calibrated0, overrun0}, '0);
    check("mid rst dut2", {acc_filt2, gyr_filt2, out_valid2, calibrated2, overrun2}, '0);
    rst = 1'b0;
    repeat (3) tick();

    check("queue dut0 drained", 128'(q0.size()), 128'(0));
    check("queue dut2 drained", 128'(q2.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
